// File: rtl/uart_regs_fifo_if.sv
// Avalon-MM slave bundle for the UART register file.
// The bus master drives the request; the register file answers.
interface uart_regs_fifo_if;
  logic [7:0]  avl_mm_addr;
  logic        avl_mm_read;
  logic [31:0] avl_mm_readdata;
  logic [1:0]  avl_mm_response;
  logic        avl_mm_write;
  logic [31:0] avl_mm_writedata;
  logic [3:0]  avl_mm_byteenable;
  logic        avl_mm_waitrequest;

  modport master (
    output avl_mm_addr,
    output avl_mm_read,
    output avl_mm_write,
    output avl_mm_writedata,
    output avl_mm_byteenable,
    input  avl_mm_readdata,
    input  avl_mm_response,
    input  avl_mm_waitrequest
  );

  modport slave (
    input  avl_mm_addr,
    input  avl_mm_read,
    input  avl_mm_write,
    input  avl_mm_writedata,
    input  avl_mm_byteenable,
    output avl_mm_readdata,
    output avl_mm_response,
    output avl_mm_waitrequest
  );
endinterface

// File: rtl/uart_regs_fifo.sv
// UART register file with TX/RX FIFOs and Avalon-MM slave decode.
// Define UART_REGS_FIFO_LOOPBACK_EN to enable CR[4] loopback.
module uart_regs_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

module uart_regs_fifo #(
  parameter int DATA_W     = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_regs_fifo_if.slave       avl,
  output logic                  irq,
  output logic [DATA_W-1:0]     data_tx,
  output logic                  data_tx_valid,
  input  logic                  data_tx_ready,
  input  logic [DATA_W-1:0]     data_rx,
  input  logic                  data_rx_valid,
  output logic [PRESCALE_W-1:0] prescale,
  input  logic                  tx_busy,
  input  logic                  rx_busy,
  input  logic                  rx_frame_error,
  input  logic                  rx_overrun_error
);
  localparam int TLW = $clog2(TX_DEPTH) + 1;
  localparam int RLW = $clog2(RX_DEPTH) + 1;

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  rd_state_e             state_q, state_d;
  logic [1:0]            cr_q, cr_d;
  logic [5:0]            ier_q, ier_d;
  logic [PRESCALE_W-1:0] prs_q, prs_d;
  logic [7:0]            txthr_q, txthr_d;
  logic [7:0]            rxthr_q, rxthr_d;
  logic [3:0]            sticky_q, sticky_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        wr_cr, wr_isr, wr_ier, wr_txd, wr_prs, wr_thr;
  logic        rd_start, rd_rxd;
  logic        tx_en, rx_en, lb;
  logic        tx_flush, rx_flush;

  logic [DATA_W-1:0] tx_head, rx_head, rx_wdata;
  logic [TLW-1:0]    tx_level;
  logic [RLW-1:0]    rx_level;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              lb_move, rx_ext, rx_drop;
  logic              tx_low, rx_high;
  logic [5:0]        isr;
  logic [3:0]        sticky_set, sticky_clr;
  logic [31:0]       rd_mux;
  logic [15:0]       prs16;
  logic              unused_ok;

  assign addr  = avl.avl_mm_addr;
  assign wdata = avl.avl_mm_writedata;
  assign be    = avl.avl_mm_byteenable;
  assign unused_ok = ^{wdata, be};

  assign wr_cr  = avl.avl_mm_write && addr == 8'h00;
  assign wr_isr = avl.avl_mm_write && addr == 8'h04;
  assign wr_ier = avl.avl_mm_write && addr == 8'h08;
  assign wr_txd = avl.avl_mm_write && addr == 8'h10 && be[0];
  assign wr_prs = avl.avl_mm_write && addr == 8'h14;
  assign wr_thr = avl.avl_mm_write && addr == 8'h1C;

  assign rd_start = avl.avl_mm_read && state_q == RD_IDLE;
  assign rd_rxd   = rd_start && addr == 8'h0C;

  assign tx_en    = cr_q[0];
  assign rx_en    = cr_q[1];
  assign tx_flush = wr_cr & be[0] & wdata[2];
  assign rx_flush = wr_cr & be[0] & wdata[3];

`ifdef UART_REGS_FIFO_LOOPBACK_EN
  logic lb_q, lb_d;

  always_comb begin
    lb_d = lb_q;
    if (wr_cr && be[0]) lb_d = wdata[4];
  end

  always_ff @(posedge clk) begin
    if (rst) lb_q <= 1'b0;
    else     lb_q <= lb_d;
  end

  assign lb = lb_q;
`else
  assign lb = 1'b0;
`endif

  assign data_tx       = tx_head;
  assign data_tx_valid = tx_en & ~tx_empty & ~lb;

  assign lb_move = lb & tx_en & rx_en & ~tx_empty & ~rx_full;
  assign tx_push = wr_txd;
  assign tx_pop  = (data_tx_valid & data_tx_ready) | lb_move;

  // Loopback owns the RX write port; external strobes are dropped then.
  assign rx_ext   = data_rx_valid & rx_en & ~lb;
  assign rx_drop  = rx_ext & rx_full;
  assign rx_push  = lb_move | rx_ext;
  assign rx_wdata = lb_move ? tx_head : data_rx;
  assign rx_pop   = rd_rxd & ~rx_empty;

  uart_regs_fifo_buf #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .wdata_i (wdata[DATA_W-1:0]),
    .rdata_o (tx_head),
    .level_o (tx_level),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  uart_regs_fifo_buf #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .wdata_i (rx_wdata),
    .rdata_o (rx_head),
    .level_o (rx_level),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign tx_low  = 32'(tx_level) <= 32'(txthr_q);
  assign rx_high = (32'(rx_level) >= 32'(rxthr_q)) && !rx_empty;
  assign isr     = {sticky_q, rx_high, tx_low};

  assign sticky_set = {
    rd_rxd & rx_empty,
    wr_txd & tx_full,
    rx_overrun_error | rx_drop,
    rx_frame_error
  };
  assign sticky_clr = (wr_isr && be[0]) ? wdata[5:2] : 4'h0;

  always_comb begin
    rd_mux = 32'h0;
    unique case (addr)
      8'h00: rd_mux = 32'({lb, 2'b00, cr_q});
      8'h04: rd_mux = 32'(isr);
      8'h08: rd_mux = 32'(ier_q);
      8'h0C: rd_mux = rx_empty ? 32'h0 : 32'(rx_head);
      8'h14: rd_mux = 32'(prs_q);
      8'h18: rd_mux = {14'h0, rx_busy, tx_busy,
                       8'(rx_level), 8'(tx_level)};
      8'h1C: rd_mux = {16'h0, rxthr_q, txthr_q};
      default: rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE: if (avl.avl_mm_read) state_d = RD_DATA;
      RD_DATA: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    cr_d     = cr_q;
    ier_d    = ier_q;
    prs_d    = prs_q;
    txthr_d  = txthr_q;
    rxthr_d  = rxthr_q;
    rdata_d  = rdata_q;
    prs16    = 16'(prs_q);
    if (wr_cr && be[0])  cr_d  = wdata[1:0];
    if (wr_ier && be[0]) ier_d = wdata[5:0];
    if (wr_prs) begin
      if (be[0]) prs16[7:0]  = wdata[7:0];
      if (be[1]) prs16[15:8] = wdata[15:8];
      prs_d = prs16[PRESCALE_W-1:0];
    end
    if (wr_thr && be[0]) txthr_d = wdata[7:0];
    if (wr_thr && be[1]) rxthr_d = wdata[15:8];
    // Sets are ORed in last so they beat a same-cycle W1C.
    sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
    if (rd_start) rdata_d = rd_mux;
    irq_d = |(isr & ier_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RD_IDLE;
      cr_q     <= '0;
      ier_q    <= '0;
      prs_q    <= '0;
      txthr_q  <= '0;
      rxthr_q  <= '0;
      sticky_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cr_q     <= cr_d;
      ier_q    <= ier_d;
      prs_q    <= prs_d;
      txthr_q  <= txthr_d;
      rxthr_q  <= rxthr_d;
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign avl.avl_mm_readdata    = rdata_q;
  assign avl.avl_mm_response    = 2'b00;
  assign avl.avl_mm_waitrequest = rd_start;
  assign prescale               = prs_q;
  assign irq                    = irq_q;
endmodule
